mod_updown_counter: RTL

Parametrised synchronous up/down counter. It is the successor to the four-bit D-flip-flop ripple counter, with configurable width and modulus, direction control, count enable, parallel load, and an optional saturating mode. Every state bit is clocked by the single system clock, so there is no ripple delay between stages. It is used as a general event, divider and address counter, and can be cascaded through its terminal-count output.

---
 rtl/mod_updown_counter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter, range 0..MODULUS-1, with load, enable, wrap or saturate.
// Latency: one clk from sampled inputs to count/wrap/sat; tc is combinational.
// Backpressure: none; en is the only throttle, and tc feeds en of a cascaded stage.
//
// Ports:
//   clk       system clock, all state changes on its rising edge
//   reset     synchronous active-high reset (count=0, wrap=0, sat=0)
//   en        count enable
//   up_dn     direction, 1 = up, 0 = down
//   load      parallel load strobe, overrides en
//   load_val  value to load, clamped to MODULUS-1
//   count     registered counter value
//   tc        terminal count: enabled and about to pass a range end
//   wrap      registered one-cycle pulse after a wrap edge
//   sat       registered level while held at a range end (SATURATE=1 only)
module mod_updown_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Range limits carried in WIDTH+1 bits so MODULUS = 2**WIDTH needs no
    // special case: the top value is then all ones in the low WIDTH bits.
    localparam longint unsigned MAX_L    = MODULUS - 64'd1;
    localparam logic [WIDTH:0]  MAX_X    = MAX_L[WIDTH:0];
    localparam logic [WIDTH:0]  ZERO_X   = '0;
    localparam logic [WIDTH:0]  ONE_X    = {{WIDTH{1'b0}}, 1'b1};
    localparam bit              SAT_MODE = (SATURATE != 0);

    logic [WIDTH:0]   count_x;
    logic [WIDTH:0]   load_x;
    logic [WIDTH:0]   next_x;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             sat_d;
    logic             at_top;
    logic             at_bot;

    assign count_x = {1'b0, count};
    assign load_x  = {1'b0, load_val};
    assign at_top  = (count_x == MAX_X);
    assign at_bot  = (count_x == ZERO_X);

    // Independent of load and SATURATE so a cascade sees a stable carry.
    assign tc = en & ((up_dn & at_top) | (~up_dn & at_bot));

    always_comb begin
        next_x = count_x;
        wrap_d = 1'b0;
        sat_d  = sat;
        if (load) begin
            next_x = (load_x > MAX_X) ? MAX_X : load_x;
            sat_d  = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                if (!at_top) begin
                    next_x = count_x + ONE_X;
                    sat_d  = 1'b0;
                end else if (SAT_MODE) begin
                    sat_d = 1'b1;
                end else begin
                    next_x = ZERO_X;
                    wrap_d = 1'b1;
                end
            end else begin
                if (!at_bot) begin
                    next_x = count_x - ONE_X;
                    sat_d  = 1'b0;
                end else if (SAT_MODE) begin
                    sat_d = 1'b1;
                end else begin
                    next_x = MAX_X;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // Final reduction keeps count inside 0..MODULUS-1 whatever the path.
    assign count_d = (next_x > MAX_X) ? MAX_X[WIDTH-1:0] : next_x[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            sat   <= sat_d;
        end
    end

endmodule
